// File: rtl/accumulator_drain_unit.sv
// accumulator_drain_unit: streams N accumulator rows into the unified buffer over valid/ready.
// Optional macro ACCUM_DRAIN_RELU_EN clamps negative signed lanes to zero on capture.

module accumulator_drain_lane #(
  parameter int ACC_W = 32
) (
  input  logic [ACC_W-1:0] din,
  output logic [ACC_W-1:0] dout
);
`ifdef ACCUM_DRAIN_RELU_EN
  assign dout = din[ACC_W-1] ? '0 : din;
`else
  assign dout = din;
`endif
endmodule

module accumulator_drain_unit #(
  parameter int MUL_SIZE   = 32,
  parameter int ACC_W      = 32,
  parameter int ACC_ADDR_W = 10,
  parameter int UB_ADDR_W  = 12
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [8:0]                  HEIGHT,
  input  logic [8:0]                  WIDTH,
  input  logic [UB_ADDR_W-1:0]        ub_base_addr_i,
  output logic                        accum_rd_en_o,
  output logic [ACC_ADDR_W-1:0]       accum_addr_rd_o,
  input  logic [MUL_SIZE*ACC_W-1:0]   accum_data_i,
  output logic                        ub_valid_o,
  input  logic                        ub_ready_i,
  output logic [UB_ADDR_W-1:0]        ub_addr_o,
  output logic [MUL_SIZE*ACC_W-1:0]   ub_data_o,
  output logic                        busy_o,
  output logic                        done_o
);

  typedef enum logic [1:0] {IDLE, DRAIN, FINISH} state_t;

  state_t                              state;
  logic [ACC_ADDR_W-1:0]               n_calc, n_rows, rd_cnt, wr_cnt, addr_q;
  logic [UB_ADDR_W-1:0]                base_q;
  logic [MUL_SIZE-1:0][ACC_W-1:0]      rd_row, push_row;
  logic [1:0][MUL_SIZE-1:0][ACC_W-1:0] fifo_mem;
  logic [1:0]                          occ;
  logic                                head, tail, rd_vld_q, pop, rd_en;
  logic [2:0]                          pend;

  // Row count is whole 32x32 tiles times 32 rows, kept at accumulator address width.
  assign n_calc = ACC_ADDR_W'((ACC_ADDR_W'(HEIGHT >> 5) * ACC_ADDR_W'(WIDTH >> 5)) << 5);

  assign ub_valid_o = (occ != 2'd0);
  assign pop        = ub_valid_o & ub_ready_i;
  assign tail       = head ^ occ[0];

  // Credit counts the slot freed by this cycle's pop so a ready sink sees one row per cycle.
  assign pend  = {1'b0, occ} + {2'b00, rd_vld_q} - {2'b00, pop};
  assign rd_en = (state == DRAIN) && (rd_cnt < n_rows) && (pend < 3'd2);

  assign accum_rd_en_o   = rd_en;
  assign accum_addr_rd_o = rd_en ? rd_cnt : addr_q;
  assign ub_data_o       = fifo_mem[head];
  assign ub_addr_o       = base_q + UB_ADDR_W'(wr_cnt);
  assign busy_o          = (state != IDLE);

  assign rd_row = accum_data_i;
  for (genvar l = 0; l < MUL_SIZE; l++) begin : g_lane
    accumulator_drain_lane #(.ACC_W(ACC_W)) u_lane (
      .din  (rd_row[l]),
      .dout (push_row[l])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_vld_q <= 1'b0;
      occ      <= 2'd0;
      head     <= 1'b0;
      fifo_mem <= '0;
    end else begin
      rd_vld_q <= rd_en;
      if (rd_vld_q) fifo_mem[tail] <= push_row;
      if (pop) head <= ~head;
      occ <= occ + {1'b0, rd_vld_q} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      n_rows <= '0;
      base_q <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
      addr_q <= '0;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          n_rows <= n_calc;
          base_q <= ub_base_addr_i;
          rd_cnt <= '0;
          wr_cnt <= '0;
          if (n_calc == '0) begin
            state  <= FINISH;
            done_o <= 1'b1;
          end else begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (rd_en) begin
            rd_cnt <= rd_cnt + ACC_ADDR_W'(1);
            addr_q <= rd_cnt;
          end
          if (pop) begin
            wr_cnt <= wr_cnt + ACC_ADDR_W'(1);
            if (wr_cnt == n_rows - ACC_ADDR_W'(1)) begin
              state  <= FINISH;
              done_o <= 1'b1;
            end
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accumulator_drain_unit.sv
// Bench for accumulator_drain_unit: RAM model plus a row scoreboard derived from the row-count rule.
module tb_accumulator_drain_unit;
  localparam int MS = 32, AW = 32, AAW = 10, UAW = 12, DW = MS * AW;

  logic           clk_i = 1'b0, rst_i = 1'b1, start_i = 1'b0, ub_ready_i = 1'b0;
  logic [8:0]     HEIGHT = '0, WIDTH = '0;
  logic [UAW-1:0] ub_base_addr_i = '0;
  logic           accum_rd_en_o, ub_valid_o, busy_o, done_o;
  logic [AAW-1:0] accum_addr_rd_o;
  logic [DW-1:0]  accum_data_i = '0, ub_data_o;
  logic [UAW-1:0] ub_addr_o;

  always #5 clk_i = ~clk_i;

  accumulator_drain_unit dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .HEIGHT(HEIGHT), .WIDTH(WIDTH),
    .ub_base_addr_i(ub_base_addr_i), .accum_rd_en_o(accum_rd_en_o),
    .accum_addr_rd_o(accum_addr_rd_o), .accum_data_i(accum_data_i),
    .ub_valid_o(ub_valid_o), .ub_ready_i(ub_ready_i), .ub_addr_o(ub_addr_o),
    .ub_data_o(ub_data_o), .busy_o(busy_o), .done_o(done_o)
  );

  logic [DW-1:0] mem [1024];
  always @(posedge clk_i) if (accum_rd_en_o) accum_data_i <= mem[accum_addr_rd_o];

  int n_checks = 0, n_fail = 0;
  int cyc, done_cnt, done_cyc, busy_cnt, stall_err, outstanding, max_out, ready_mode;
  bit timed_out;
  int rd_cyc[$], hs_cyc[$];
  logic [AAW-1:0] rd_addr[$];
  logic [UAW-1:0] hs_addr[$];
  logic [DW-1:0]  hs_data[$];
  logic           stalled_q;
  logic [UAW-1:0] st_addr;
  logic [DW-1:0]  st_data;

  function automatic int exp_rows(int h, int w);
    return ((h / 32) * (w / 32) * 32) % 1024;
  endfunction

  function automatic logic [DW-1:0] exp_data(int i);
    logic [DW-1:0] r;
    r = mem[i];
`ifdef ACCUM_DRAIN_RELU_EN
    for (int l = 0; l < MS; l++) if ($signed(r[l*AW +: AW]) < 0) r[l*AW +: AW] = '0;
`endif
    return r;
  endfunction

  task automatic clear();
    rd_cyc.delete(); rd_addr.delete(); hs_cyc.delete(); hs_addr.delete(); hs_data.delete();
    done_cnt = 0; done_cyc = -1; busy_cnt = 0; stall_err = 0; outstanding = 0; max_out = 0;
    stalled_q = 1'b0; timed_out = 1'b0;
  endtask

  // Observe the current cycle at the falling edge, then move to just after the next rising edge.
  task automatic tick();
    @(negedge clk_i);
    if (accum_rd_en_o) begin rd_addr.push_back(accum_addr_rd_o); rd_cyc.push_back(cyc); outstanding++; end
    if (stalled_q && (!ub_valid_o || ub_addr_o !== st_addr || ub_data_o !== st_data)) stall_err++;
    stalled_q = ub_valid_o && !ub_ready_i; st_addr = ub_addr_o; st_data = ub_data_o;
    if (ub_valid_o && ub_ready_i) begin
      hs_addr.push_back(ub_addr_o); hs_data.push_back(ub_data_o); hs_cyc.push_back(cyc); outstanding--;
    end
    if (outstanding > max_out) max_out = outstanding;
    if (done_o) begin done_cnt++; done_cyc = cyc; end
    if (busy_o) busy_cnt++;
    @(posedge clk_i); #1; cyc++;
    if (ready_mode == 1) ub_ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic drain(input logic [8:0] h, input logic [8:0] w, input logic [UAW-1:0] base,
                       input int restart_at);
    clear();
    HEIGHT = h; WIDTH = w; ub_base_addr_i = base; start_i = 1'b1; cyc = 0;
    tick();
    while (done_cnt == 0 && cyc < 4000) begin
      start_i = (cyc == restart_at);
      if (start_i) begin HEIGHT = 9'd64; WIDTH = 9'd64; ub_base_addr_i = 12'h3AB; end
      tick();
    end
    start_i = 1'b0;
    timed_out = (done_cnt == 0);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_i = 1'b1; ready_mode = 0; ub_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    n_checks++; if (accum_rd_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", accum_rd_en_o); end
    n_checks++; if (accum_addr_rd_o !== '0) begin n_fail++; $display("FAIL reset_rd_addr: got %0h want 0", accum_addr_rd_o); end
    n_checks++; if (ub_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ub_valid_o); end
    n_checks++; if (ub_addr_o !== '0 || ub_data_o !== '0) begin n_fail++; $display("FAIL reset_ub: addr %0h data_lane0 %0h want 0", ub_addr_o, ub_data_o[31:0]); end
    n_checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done: got %b%b want 00", busy_o, done_o); end
    @(posedge clk_i); #1; rst_i = 1'b0;
  endtask

  task automatic test_basic();
    bit seq_ok;
    ready_mode = 0; ub_ready_i = 1'b1;
    drain(9'd32, 9'd32, 12'h100, -1);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL basic_timeout: no done within bound"); end
    n_checks++; if (rd_addr.size() != 32) begin n_fail++; $display("FAIL basic_reads: got %0d want 32", rd_addr.size()); end
    seq_ok = 1'b1;
    foreach (rd_addr[i]) if (rd_addr[i] !== AAW'(i) || rd_cyc[i] != i + 1) seq_ok = 1'b0;
    n_checks++; if (!seq_ok) begin n_fail++; $display("FAIL basic_read_seq: got out-of-order read addr/cycle, want addr i at cycle i+1"); end
    n_checks++; if (hs_cyc.size() != 32 || hs_cyc[0] != 3 || hs_cyc[31] != 34) begin
      n_fail++; $display("FAIL basic_hs_cycles: got %0d rows, want 32 rows in cycles 3..34", hs_cyc.size()); end
    n_checks++; if (done_cyc != 35 || done_cnt != 1) begin n_fail++; $display("FAIL basic_done: got cycle %0d count %0d want 35/1", done_cyc, done_cnt); end
    foreach (hs_data[i]) begin
      n_checks++;
      if (hs_data[i] !== exp_data(i) || hs_addr[i] !== UAW'(12'h100 + i)) begin
        n_fail++; $display("FAIL basic_row %0d: got addr %0h lane0 %0h want addr %0h lane0 %0h",
                           i, hs_addr[i], hs_data[i][31:0], UAW'(12'h100 + i), exp_data(i) & 32'hFFFF_FFFF);
      end
    end
  endtask

  task automatic test_large();
    ready_mode = 0; ub_ready_i = 1'b1;
    drain(9'd64, 9'd64, 12'h000, -1);
    n_checks++; if (rd_addr.size() != exp_rows(64, 64) || rd_addr[rd_addr.size()-1] !== AAW'(127)) begin
      n_fail++; $display("FAIL large_reads: got %0d reads want %0d ending at 127", rd_addr.size(), exp_rows(64, 64)); end
    n_checks++; if (hs_data.size() != 128) begin n_fail++; $display("FAIL large_hs: got %0d want 128", hs_data.size()); end
    n_checks++; if (done_cnt != 1 || done_cyc != 131) begin n_fail++; $display("FAIL large_done: got count %0d cycle %0d want 1/131", done_cnt, done_cyc); end
    foreach (hs_data[i]) begin
      n_checks++;
      if (hs_data[i] !== exp_data(i) || hs_addr[i] !== UAW'(i)) begin
        n_fail++; $display("FAIL large_row %0d: got addr %0h lane0 %0h want addr %0h", i, hs_addr[i], hs_data[i][31:0], i);
      end
    end
  endtask

  task automatic test_backpressure();
    ready_mode = 1; ub_ready_i = 1'b0;
    drain(9'd64, 9'd32, 12'hFE0, -1);
    ready_mode = 0; ub_ready_i = 1'b1;
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL bp_timeout: no done within bound"); end
    n_checks++; if (stall_err != 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes while stalled want 0", stall_err); end
    n_checks++; if (max_out > 2) begin n_fail++; $display("FAIL bp_credit: got %0d outstanding want <=2", max_out); end
    n_checks++; if (hs_data.size() != exp_rows(64, 32) || rd_addr.size() != exp_rows(64, 32)) begin
      n_fail++; $display("FAIL bp_count: got %0d rows %0d reads want %0d", hs_data.size(), rd_addr.size(), exp_rows(64, 32)); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL bp_done: got %0d want 1", done_cnt); end
    foreach (hs_data[i]) begin
      n_checks++;
      if (hs_data[i] !== exp_data(i) || hs_addr[i] !== UAW'(12'hFE0 + i)) begin
        n_fail++; $display("FAIL bp_row %0d: got addr %0h lane0 %0h want addr %0h", i, hs_addr[i], hs_data[i][31:0], UAW'(12'hFE0 + i));
      end
    end
  endtask

  task automatic test_zero_rows();
    ready_mode = 0; ub_ready_i = 1'b1;
    drain(9'd16, 9'd64, 12'h055, -1);
    n_checks++; if (rd_addr.size() != 0) begin n_fail++; $display("FAIL zero_reads: got %0d want 0", rd_addr.size()); end
    n_checks++; if (done_cyc != 1 || done_cnt != 1) begin n_fail++; $display("FAIL zero_done: got cycle %0d count %0d want 1/1", done_cyc, done_cnt); end
    n_checks++; if (busy_cnt != 1) begin n_fail++; $display("FAIL zero_busy: got %0d cycles want 1", busy_cnt); end
  endtask

  task automatic test_restart_ignored();
    ready_mode = 0; ub_ready_i = 1'b1;
    drain(9'd32, 9'd32, 12'h040, 10);
    n_checks++; if (hs_data.size() != 32 || done_cnt != 1 || done_cyc != 35) begin
      n_fail++; $display("FAIL restart_count: got %0d rows done %0d@%0d want 32 rows done 1@35", hs_data.size(), done_cnt, done_cyc); end
    foreach (hs_addr[i]) begin
      n_checks++;
      if (hs_addr[i] !== UAW'(12'h040 + i) || hs_data[i] !== exp_data(i)) begin
        n_fail++; $display("FAIL restart_row %0d: got addr %0h want %0h", i, hs_addr[i], UAW'(12'h040 + i));
      end
    end
  endtask

  task automatic test_reset_mid();
    ready_mode = 0; ub_ready_i = 1'b1;
    clear();
    HEIGHT = 9'd64; WIDTH = 9'd64; ub_base_addr_i = 12'h200; start_i = 1'b1; cyc = 0;
    tick(); start_i = 1'b0;
    repeat (10) tick();
    rst_i = 1'b1; #1;
    n_checks++;
    if ({accum_rd_en_o, accum_addr_rd_o, ub_valid_o, ub_addr_o, busy_o, done_o} !== '0 || ub_data_o !== '0) begin
      n_fail++; $display("FAIL midreset_outputs: got rd %b addr %0h valid %b ubaddr %0h busy %b want all 0",
                         accum_rd_en_o, accum_addr_rd_o, ub_valid_o, ub_addr_o, busy_o);
    end
    repeat (2) tick();
    rst_i = 1'b0;
    repeat (4) tick();
    n_checks++; if (done_cnt != 0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL midreset_done: got done %0d busy %b want 0/0", done_cnt, busy_o); end
  endtask

  task automatic test_relu();
    logic [31:0] want0;
    mem[0][31:0] = 32'hFFFF_FFF0; mem[0][63:32] = 32'h0000_0005;
`ifdef ACCUM_DRAIN_RELU_EN
    want0 = 32'h0;
`else
    want0 = 32'hFFFF_FFF0;
`endif
    ready_mode = 0; ub_ready_i = 1'b1;
    drain(9'd32, 9'd32, 12'h000, -1);
    n_checks++;
    if (hs_data.size() == 0) begin n_fail++; $display("FAIL relu_rows: got 0 rows want 32"); end
    else if (hs_data[0][31:0] !== want0 || hs_data[0][63:32] !== 32'h5) begin
      n_fail++; $display("FAIL relu_lanes: got %0h/%0h want %0h/5", hs_data[0][31:0], hs_data[0][63:32], want0);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++)
      for (int l = 0; l < MS; l++) mem[i][l*AW +: AW] = $urandom;
    cyc = 0; ready_mode = 0;
    clear();
    test_reset();
    test_basic();
    test_large();
    test_backpressure();
    test_zero_rows();
    test_restart_ignored();
    test_reset_mid();
    test_relu();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time bound");
    $fatal(1);
  end
endmodule
